mem_arbiter: RTL

Sequencer that shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time over valid/ready handshakes, forwards it to the memory port, waits for the memory response and returns it to the granted requester. It sits between the IFU/LSU and the memory block, so the memory block only ever sees one access in flight.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic       GNT_IFU     = 1'b0;
  localparam logic       GNT_LSU     = 1'b1;
  localparam logic [2:0] MEM_OP_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU.
// MEM_ARB_RR_EN: round-robin with a last-winner pointer; otherwise LSU has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic any,
  output logic gnt
);

  assign any = ifu_valid | lsu_valid;

`ifdef MEM_ARB_RR_EN
  logic last;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt = GNT_IFU;
    if (ifu_valid && lsu_valid) gnt = ~last;
    else if (lsu_valid)         gnt = GNT_LSU;
  end

  // Reset to "LSU won last" so the first tie favours the IFU.
  always_ff @(posedge clk) begin
    if (rst)       last <= GNT_LSU;
    else if (take) last <= gnt;
  end
`else
  assign gnt = lsu_valid ? GNT_LSU : GNT_IFU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU accesses onto one memory port, one access in flight.
// MEM_ARB_RR_EN enables round-robin arbitration (default: fixed LSU priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_req_valid,
  output logic             ifu_req_ready,
  input  logic [WIDTH-1:0] ifu_addr,
  output logic             ifu_rsp_valid,
  output logic [WIDTH-1:0] ifu_rsp_data,
  input  logic             lsu_req_valid,
  output logic             lsu_req_ready,
  input  logic             lsu_we,
  input  logic [2:0]       lsu_op,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  output logic             lsu_rsp_valid,
  output logic [WIDTH-1:0] lsu_rsp_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [2:0]       mem_op,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data
);

  state_t           state;
  logic             gnt_q;
  logic [WIDTH-1:0] rsp_q;
  logic             any;
  logic             gnt;
  logic             accept;

  assign accept = (state == ST_IDLE) && any && !rst;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .take      (accept),
`endif
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .any       (any),
    .gnt       (gnt)
  );

  assign ifu_req_ready = accept && (gnt == GNT_IFU);
  assign lsu_req_ready = accept && (gnt == GNT_LSU);
  assign mem_req_valid = (state == ST_REQ);

  // Response data is only driven towards the side that owns the access.
  assign ifu_rsp_valid = (state == ST_RESP) && (gnt_q == GNT_IFU);
  assign lsu_rsp_valid = (state == ST_RESP) && (gnt_q == GNT_LSU);
  assign ifu_rsp_data  = ifu_rsp_valid ? rsp_q : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? rsp_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_q     <= GNT_IFU;
      mem_we    <= 1'b0;
      mem_op    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt_q <= gnt;
            state <= ST_REQ;
            if (gnt == GNT_LSU) begin
              mem_we    <= lsu_we;
              mem_op    <= lsu_op;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_op    <= MEM_OP_WORD;
              mem_addr  <= ifu_addr;
              mem_wdata <= '0;
            end
          end
        end
        // A response is only meaningful once the request handshake completes.
        ST_REQ: begin
          if (mem_req_ready) begin
            if (mem_rsp_valid) begin
              rsp_q <= mem_we ? '0 : mem_rsp_data;
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_q <= mem_we ? '0 : mem_rsp_data;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
